uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_pkg.sv | 14 +
 rtl/sync_fifo.sv | 75 +++++++
 rtl/uart_tx_fifo.sv | 91 +++++++++
 tb/tb_uart_tx_fifo.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and types for the UART transmit FIFO.
// Send FSM encoding and default geometry live here.
package uart_tx_fifo_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF    = 4;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_REQ       = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular byte buffer with occupancy count and sticky overflow.
// Full, empty and count decode straight from registers.
module sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  byte_t         wr_data,
  input  logic          rd_en,
  output byte_t         rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  input  logic          ovf_clear,
  output logic          overflow
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          wr_acc, rd_acc;
  byte_t         mem [DEPTH];

  assign full     = (cnt_q == FULL_CNT);
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign overflow = ovf_q;
  assign rd_data  = mem[rptr_q];

  // A pop never frees room for a write in the same cycle.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) rptr_d = rptr_q + 1'b1;
    unique case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (ovf_clear)    ovf_d = 1'b0;
    if (wr_en & full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a
// request / busy handshake driven by a 3-state send FSM.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          ovf_clear,
  output logic          tx_en,
  output logic [7:0]    tx_data,
  input  logic          tx_busy
);

  logic [1:0] state_q, state_d;
  logic       tx_en_q, tx_en_d;
  byte_t      tx_data_q, tx_data_d;
  byte_t      head;
  logic       pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (sys_clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (pop),
    .rd_data   (head),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .ovf_clear (ovf_clear),
    .overflow  (overflow)
  );

  assign tx_en   = tx_en_q;
  assign tx_data = tx_data_q;

  always_comb begin
    state_d   = state_q;
    tx_en_d   = tx_en_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (!empty && !tx_busy) begin
          pop       = 1'b1;
          tx_data_d = head;
          tx_en_d   = 1'b1;
          state_d   = ST_REQ;
        end
      end
      (state_q == ST_REQ): begin
        if (tx_busy) begin
          tx_en_d = 1'b0;
          state_d = ST_WAIT_DONE;
        end
      end
      (state_q == ST_WAIT_DONE): begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: begin
        tx_en_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple
// busy-pulse UART model collecting transmitted bytes.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       ovf_clear;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       man_busy;

  int vectors     = 0;
  int miscompares = 0;

  bit         uart_auto = 1'b0;
  int         busy_len  = 10;
  int         bcnt      = 0;
  logic       mbusy     = 1'b0;
  logic [7:0] rxq [$];

  always #5 clk = ~clk;

  assign tx_busy = uart_auto ? mbusy : man_busy;

  uart_tx_fifo #(
    .DEPTH (16),
    .AW    (4)
  ) dut (
    .sys_clk   (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .ovf_clear (ovf_clear),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy)
  );

  // UART model: accept a request, then stay busy for busy_len edges.
  always @(posedge clk) begin
    #2;
    if (!uart_auto) begin
      mbusy = 1'b0;
      bcnt  = 0;
    end else if (bcnt > 0) begin
      bcnt = bcnt - 1;
      if (bcnt == 0) mbusy = 1'b0;
    end else if (tx_en && !mbusy) begin
      rxq.push_back(tx_data);
      mbusy = 1'b1;
      bcnt  = busy_len;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    uart_auto = 1'b0;
    man_busy  = 1'b0;
    wr_en     = 1'b0;
    ovf_clear = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    ovf_clear = 1'b0;
    man_busy  = 1'b0;
    tick();
    vectors++;
    if (empty !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_empty got %b want 1", empty);
    end
    vectors++;
    if (full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_full got %b want 0", full);
    end
    vectors++;
    if (count !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_count got %0d want 0", count);
    end
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ovf got %b want 0", overflow);
    end
    vectors++;
    if (tx_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_tx_en got %b want 0", tx_en);
    end
    vectors++;
    if (tx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_tx_data got %h want 00", tx_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit seen;
    do_reset();
    wr_en   = 1'b1;
    wr_data = 8'h41;
    tick();
    wr_en = 1'b0;
    vectors++;
    if (tx_en !== 1'b0 || count !== 5'd1) begin
      miscompares++;
      $display("FAIL single_write got en=%b cnt=%0d want en=0 cnt=1",
               tx_en, count);
    end
    tick();
    vectors++;
    if (tx_en !== 1'b1 || tx_data !== 8'h41) begin
      miscompares++;
      $display("FAIL single_req got en=%b data=%h want en=1 data=41",
               tx_en, tx_data);
    end
    vectors++;
    if (empty !== 1'b1) begin
      miscompares++;
      $display("FAIL single_empty got %b want 1", empty);
    end
    tick();
    vectors++;
    if (tx_en !== 1'b1 || tx_data !== 8'h41) begin
      miscompares++;
      $display("FAIL single_hold got en=%b data=%h want en=1 data=41",
               tx_en, tx_data);
    end
    man_busy = 1'b1;
    tick();
    vectors++;
    if (tx_en !== 1'b0) begin
      miscompares++;
      $display("FAIL single_ack got %b want 0", tx_en);
    end
    man_busy = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (tx_en) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL single_idle got seen=%b empty=%b want 0 1",
               seen, empty);
    end
  endtask

  task automatic test_burst();
    do_reset();
    rxq.delete();
    busy_len  = 10;
    uart_auto = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h30 + i);
      tick();
    end
    wr_en = 1'b0;
    for (int c = 0; c < 300 && rxq.size() < 4; c++) tick();
    repeat (30) tick();
    vectors++;
    if (rxq.size() !== 4) begin
      miscompares++;
      $display("FAIL burst_size got %0d want 4", rxq.size());
    end
    for (int i = 0; i < 4 && i < rxq.size(); i++) begin
      vectors++;
      if (rxq[i] !== 8'(8'h30 + i)) begin
        miscompares++;
        $display("FAIL burst_byte%0d got %h want %h",
                 i, rxq[i], 8'(8'h30 + i));
      end
    end
  endtask

  task automatic test_full_overflow();
    do_reset();
    man_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h50 + i);
      tick();
    end
    wr_en = 1'b0;
    vectors++;
    if (full !== 1'b1 || count !== 5'd16) begin
      miscompares++;
      $display("FAIL full_state got full=%b cnt=%0d want 1 16",
               full, count);
    end
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL full_ovf got %b want 1", overflow);
    end
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    vectors++;
    if (overflow !== 1'b0 || count !== 5'd16) begin
      miscompares++;
      $display("FAIL ovf_clear got ovf=%b cnt=%0d want 0 16",
               overflow, count);
    end
    wr_en     = 1'b1;
    wr_data   = 8'hEE;
    ovf_clear = 1'b1;
    tick();
    wr_en = 1'b0;
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set_wins got %b want 1", overflow);
    end
    tick();
    ovf_clear = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear2 got %b want 0", overflow);
    end
    rxq.delete();
    busy_len  = 2;
    uart_auto = 1'b1;
    for (int c = 0; c < 600 && rxq.size() < 16; c++) tick();
    repeat (30) tick();
    vectors++;
    if (rxq.size() !== 16 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL full_drain got n=%0d empty=%b want 16 1",
               rxq.size(), empty);
    end
    for (int i = 0; i < 16 && i < rxq.size(); i++) begin
      vectors++;
      if (rxq[i] !== 8'(8'h50 + i)) begin
        miscompares++;
        $display("FAIL full_byte%0d got %h want %h",
                 i, rxq[i], 8'(8'h50 + i));
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    man_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h70 + i);
      tick();
    end
    wr_en = 1'b0;
    vectors++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_pre got full=%b ovf=%b want 1 0",
               full, overflow);
    end
    wr_en    = 1'b1;
    wr_data  = 8'hEE;
    man_busy = 1'b0;
    tick();
    wr_en = 1'b0;
    vectors++;
    if (count !== 5'd15 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_drop got cnt=%0d ovf=%b want 15 1",
               count, overflow);
    end
    vectors++;
    if (tx_en !== 1'b1 || tx_data !== 8'h70) begin
      miscompares++;
      $display("FAIL simul_pop got en=%b data=%h want 1 70",
               tx_en, tx_data);
    end
    man_busy = 1'b1;
    tick();
    rxq.delete();
    busy_len  = 2;
    uart_auto = 1'b1;
    for (int c = 0; c < 600 && rxq.size() < 15; c++) tick();
    repeat (30) tick();
    vectors++;
    if (rxq.size() !== 15) begin
      miscompares++;
      $display("FAIL simul_drain got %0d want 15", rxq.size());
    end
    for (int i = 0; i < 15 && i < rxq.size(); i++) begin
      vectors++;
      if (rxq[i] !== 8'(8'h71 + i)) begin
        miscompares++;
        $display("FAIL simul_byte%0d got %h want %h",
                 i, rxq[i], 8'(8'h71 + i));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    man_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'hA0 + i);
      tick();
    end
    wr_en    = 1'b0;
    man_busy = 1'b0;
    tick();
    vectors++;
    if (tx_en !== 1'b1 || count !== 5'd5 || tx_data !== 8'hA0) begin
      miscompares++;
      $display("FAIL rstmid_req got en=%b cnt=%0d data=%h want 1 5 a0",
               tx_en, count, tx_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (tx_en !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_async got en=%b cnt=%0d empty=%b want 0 0 1",
               tx_en, count, empty);
    end
    vectors++;
    if (tx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL rstmid_data got %h want 00", tx_data);
    end
    tick();
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (12) begin
      tick();
      if (tx_en) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_quiet got seen=%b empty=%b want 0 1",
               seen, empty);
    end
    wr_en   = 1'b1;
    wr_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    tick();
    vectors++;
    if (tx_en !== 1'b1 || tx_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL rstmid_new got en=%b data=%h want 1 5a",
               tx_en, tx_data);
    end
  endtask

  task automatic test_wrap();
    int sent;
    do_reset();
    rxq.delete();
    busy_len  = 1;
    uart_auto = 1'b1;
    sent      = 0;
    for (int c = 0; c < 3000 && sent < 40; c++) begin
      if (!full) begin
        wr_en   = 1'b1;
        wr_data = 8'(8'h80 + sent);
        sent++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    for (int c = 0; c < 1000 && rxq.size() < 40; c++) tick();
    repeat (20) tick();
    vectors++;
    if (rxq.size() !== 40 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_size got n=%0d ovf=%b want 40 0",
               rxq.size(), overflow);
    end
    for (int i = 0; i < 40 && i < rxq.size(); i++) begin
      vectors++;
      if (rxq[i] !== 8'(8'h80 + i)) begin
        miscompares++;
        $display("FAIL wrap_byte%0d got %h want %h",
                 i, rxq[i], 8'(8'h80 + i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full_overflow();
    test_simultaneous();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
